// File: rtl/sp_ram_pl_pkg.sv
// Shared types and helpers for the pipelined single-port RAM.
// Parity support in the RAM is enabled with SP_RAM_PARITY_EN.
package sp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RD_LAT_MAX = 4;
  localparam int MAX_BYTES  = 32;

  // Even parity of every byte lane; callers cast the result down to their lane count.
  function automatic logic [MAX_BYTES-1:0] byte_par(input logic [8*MAX_BYTES-1:0] d);
    logic [MAX_BYTES-1:0] r;
    for (int i = 0; i < MAX_BYTES; i++) r[i] = ^d[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/sp_ram_pl_if.sv
// Access bus of sp_ram_pl: request side driven by the master, read return by the RAM.
// Parity lanes are always present; they only carry meaning with SP_RAM_PARITY_EN.
interface sp_ram_pl_if #(
  parameter int ADD_WD  = 4,
  parameter int DATA_WD = 32
);
  logic                   cs;
  logic                   rnw;
  logic [ADD_WD-1:0]      add;
  logic [DATA_WD-1:0]     wr_data;
  logic [DATA_WD/8-1:0]   wr_be;
  logic                   par_inj;
  logic [DATA_WD-1:0]     rd_data;
  logic                   rd_valid;
  logic [DATA_WD/8-1:0]   rd_perr;
  logic                   busy;

  modport master (
    output cs, rnw, add, wr_data, wr_be, par_inj,
    input  rd_data, rd_valid, rd_perr, busy
  );

  modport slave (
    input  cs, rnw, add, wr_data, wr_be, par_inj,
    output rd_data, rd_valid, rd_perr, busy
  );
endinterface

// File: rtl/sp_ram_pl_rd_pipe.sv
// Delay line for read returns; data only advances with its valid so the tail holds.
// Used by sp_ram_pl regardless of SP_RAM_PARITY_EN; STAGES = 0 is a pass-through.
module sp_ram_rd_pipe #(
  parameter int WIDTH  = 36,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_pipe_q [STAGES:0];
  logic [WIDTH-1:0] dat_pipe_q [STAGES:0];

  assign vld_pipe_q[0] = vld_i;
  assign dat_pipe_q[0] = dat_i;

  for (genvar s = 1; s <= STAGES; s++) begin : g_stg
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe_q[s] <= 1'b0;
        dat_pipe_q[s] <= '0;
      end else begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        if (vld_pipe_q[s-1]) dat_pipe_q[s] <= dat_pipe_q[s-1];
      end
    end
  end

  if (STAGES == 0) begin : g_thru
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end

  assign vld_o = vld_pipe_q[STAGES];
  assign dat_o = dat_pipe_q[STAGES];

endmodule

// File: rtl/sp_ram_pl.sv
// Single-port RAM with byte enables, post-reset hardware clear and registered read latency.
// Define SP_RAM_PARITY_EN to store and check one even-parity bit per byte.
module sp_ram_pl
  import sp_ram_pkg::*;
#(
  parameter int add_wd  = 4,
  parameter int data_wd = 32,
  parameter int depth   = 16,
  parameter int rd_lat  = 2,
  parameter int wr_thru = 0
) (
  input  logic    clk,
  input  logic    rst,
  sp_ram_pl_if.slave bus
);

  localparam int NB = data_wd / 8;
  localparam int PW = data_wd + NB;

  if ((data_wd % 8) != 0 || depth > (1 << add_wd) || rd_lat < 1 || rd_lat > RD_LAT_MAX)
  begin : g_bad_cfg
    $error("sp_ram_pl: illegal parameter combination");
  end

  state_e              state_q, state_d;
  logic [add_wd-1:0]   cnt_q, cnt_d;
  logic                clr_we, acc, in_rng, wr_en, launch;
  logic [data_wd-1:0]  rd_word, merged, s1_dat_d;
  logic [NB-1:0]       s1_perr_d;
  logic                s1_vld_q;
  logic [data_wd-1:0]  s1_dat_q;
  logic [NB-1:0]       s1_perr_q;
  logic                pipe_vld;
  logic [PW-1:0]       pipe_dat;
  logic [data_wd-1:0]  mem_q [depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == add_wd'(depth - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign acc    = bus.cs && (state_q == ST_READY);
  assign in_rng = int'(bus.add) < depth;
  assign wr_en  = acc && !bus.rnw && in_rng;
  assign launch = acc && (bus.rnw || (wr_thru != 0));

  always_comb begin
    rd_word = in_rng ? mem_q[bus.add] : '0;
    for (int b = 0; b < NB; b++)
      merged[8*b +: 8] = bus.wr_be[b] ? bus.wr_data[8*b +: 8] : rd_word[8*b +: 8];
    s1_dat_d = '0;
    if (in_rng) s1_dat_d = bus.rnw ? rd_word : merged;
  end

  // Memory is left alone while rst is high, so a write coinciding with reset is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < NB; b++)
          if (bus.wr_be[b]) mem_q[bus.add][8*b +: 8] <= bus.wr_data[8*b +: 8];
      end
    end
  end

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] par_q [depth];
  logic [NB-1:0] par_rd, wpar, par_new, par_sel;

  always_comb begin
    par_rd  = in_rng ? par_q[bus.add] : '0;
    wpar    = NB'(byte_par((8*MAX_BYTES)'(bus.wr_data))) ^ {NB{bus.par_inj}};
    par_new = (bus.wr_be & wpar) | (~bus.wr_be & par_rd);
    par_sel = bus.rnw ? par_rd : par_new;
    s1_perr_d = '0;
    if (in_rng) s1_perr_d = NB'(byte_par((8*MAX_BYTES)'(s1_dat_d))) ^ par_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        par_q[cnt_q] <= '0;
      end else if (wr_en) begin
        for (int b = 0; b < NB; b++)
          if (bus.wr_be[b]) par_q[bus.add][b] <= wpar[b];
      end
    end
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = bus.par_inj;
  assign s1_perr_d      = '0;
`endif

  // Stage 1: registered array read; data only loads on a launch so the output holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      s1_perr_q <= '0;
    end else begin
      s1_vld_q <= launch;
      if (launch) begin
        s1_dat_q  <= s1_dat_d;
        s1_perr_q <= s1_perr_d;
      end
    end
  end

  sp_ram_rd_pipe #(
    .WIDTH  (PW),
    .STAGES (rd_lat - 1)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (s1_vld_q),
    .dat_i ({s1_perr_q, s1_dat_q}),
    .vld_o (pipe_vld),
    .dat_o (pipe_dat)
  );

  assign bus.rd_data  = pipe_dat[data_wd-1:0];
  assign bus.rd_valid = pipe_vld;
  assign bus.rd_perr  = pipe_vld ? pipe_dat[PW-1:data_wd] : '0;
  assign bus.busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sp_ram_pl.sv
// Bench for sp_ram_pl: two instances (plain depth 16, and write-through depth 12) checked
// every cycle against a word/byte-level reference model; honours SP_RAM_PARITY_EN.
module tb_sp_ram_pl;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int RL = 2;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [NB-1:0] p;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, cs, rnw, par_inj;
  logic [AW-1:0] add;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_be;

  always #5 clk = ~clk;

  sp_ram_pl_if #(.ADD_WD(AW), .DATA_WD(DW)) bus0 ();
  sp_ram_pl_if #(.ADD_WD(AW), .DATA_WD(DW)) bus1 ();

  assign bus0.cs = cs;  assign bus0.rnw = rnw;  assign bus0.add = add;
  assign bus0.wr_data = wr_data;  assign bus0.wr_be = wr_be;  assign bus0.par_inj = par_inj;
  assign bus1.cs = cs;  assign bus1.rnw = rnw;  assign bus1.add = add;
  assign bus1.wr_data = wr_data;  assign bus1.wr_be = wr_be;  assign bus1.par_inj = par_inj;

  sp_ram_pl #(.add_wd(AW), .data_wd(DW), .depth(16), .rd_lat(RL), .wr_thru(0)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  sp_ram_pl #(.add_wd(AW), .data_wd(DW), .depth(12), .rd_lat(RL), .wr_thru(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  // Reference model: word array, per-byte "parity is wrong" flags, clear countdown,
  // and a return delay line (RL >= 2 assumed).
  int            dep_a [2] = '{16, 12};
  bit            thru_a [2] = '{1'b0, 1'b1};
  logic [DW-1:0] mem [2][16];
  logic [NB-1:0] pfl [2][16];
  int            clr [2];
  ent_t          dl  [2][RL];
  logic          ov  [2];
  logic [DW-1:0] od  [2];
  logic [NB-1:0] op  [2];
  int            vectors = 0;
  int            errs = 0;

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      ent_t nw;
      ent_t o;
      bit   inr;
      nw = '0;
      if (rst) begin
        clr[k] = dep_a[k];
        for (int j = 0; j < RL; j++) dl[k][j] = '0;
        ov[k] = 1'b0;
        od[k] = '0;
        op[k] = '0;
      end else begin
        if (clr[k] > 0) begin
          mem[k][dep_a[k] - clr[k]] = '0;
          pfl[k][dep_a[k] - clr[k]] = '0;
          clr[k]--;
        end else if (cs) begin
          inr = int'(add) < dep_a[k];
          if (!rnw && inr) begin
            for (int b = 0; b < NB; b++) begin
              if (wr_be[b]) begin
                mem[k][add][8*b +: 8] = wr_data[8*b +: 8];
`ifdef SP_RAM_PARITY_EN
                pfl[k][add][b] = par_inj;
`endif
              end
            end
          end
          if (rnw || thru_a[k]) begin
            nw.v = 1'b1;
            if (inr) begin
              nw.d = mem[k][add];
              nw.p = pfl[k][add];
            end
          end
        end
        o = dl[k][0];
        for (int j = 0; j < RL - 2; j++) dl[k][j] = dl[k][j+1];
        dl[k][RL-2] = nw;
        ov[k] = o.v;
        if (o.v) od[k] = o.d;
        op[k] = o.v ? o.p : '0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy0",  DW'(bus0.busy),     DW'(clr[0] > 0));
    chk("valid0", DW'(bus0.rd_valid), DW'(ov[0]));
    chk("data0",  bus0.rd_data,       od[0]);
    chk("perr0",  DW'(bus0.rd_perr),  DW'(op[0]));
    chk("busy1",  DW'(bus1.busy),     DW'(clr[1] > 0));
    chk("valid1", DW'(bus1.rd_valid), DW'(ov[1]));
    chk("data1",  bus1.rd_data,       od[1]);
    chk("perr1",  DW'(bus1.rd_perr),  DW'(op[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    cs = 1'b0; rnw = 1'b1; wr_be = '0; par_inj = 1'b0;
    tick();
  endtask

  task automatic rd(input int a);
    cs = 1'b1; rnw = 1'b1; add = AW'(a); wr_be = '0; par_inj = 1'b0;
    tick();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [NB-1:0] be, input logic inj);
    cs = 1'b1; rnw = 1'b0; add = AW'(a); wr_data = d; wr_be = be; par_inj = inj;
    tick();
  endtask

  task automatic rnd_op();
    cs      = ($urandom_range(0, 3) != 0);
    rnw     = $urandom_range(0, 1) == 1;
    add     = AW'($urandom_range(0, 15));
    wr_data = $urandom;
    wr_be   = NB'($urandom_range(0, 15));
    par_inj = ($urandom_range(0, 7) == 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; rnw = 1'b1; add = '0; wr_data = '0; wr_be = '0; par_inj = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clr[k] = 0; ov[k] = 1'b0; od[k] = '0; op[k] = '0;
      for (int j = 0; j < RL; j++) dl[k][j] = '0;
    end

    // Power-up reset, then clear window with random accesses that must be ignored
    repeat (3) tick();
    rst = 1'b0;
    repeat (16) rnd_op();
    idle();

    // Everything reads back as zero after clear, streamed back to back
    for (int a = 0; a < 16; a++) rd(a);
    repeat (3) idle();

    // Byte-enable merge on address 3
    wr(3, 32'hAABBCCDD, 4'b1111, 1'b0);
    wr(3, 32'h11223344, 4'b0101, 1'b0);
    rd(3);
    repeat (3) idle();

    // Write-through and read-after-write on address 5
    wr(5, 32'hDEADBEEF, 4'b1111, 1'b0);
    rd(5);
    repeat (3) idle();

    // Fill, then stream all addresses including out-of-range ones for the depth-12 part
    for (int a = 0; a < 16; a++) wr(a, $urandom, 4'b1111, 1'b0);
    for (int a = 0; a < 16; a++) rd(a);
    repeat (3) idle();

    repeat (200) rnd_op();
    idle();

    // Reset landing at clear count 7 restarts the clear
    rst = 1'b1; idle();
    rst = 1'b0;
    repeat (7) rnd_op();
    rst = 1'b1; rd(2);
    rst = 1'b0;
    repeat (18) rnd_op();

    // Read in flight when reset hits, plus a write sampled together with reset
    wr(4, 32'h0BADF00D, 4'b1111, 1'b0);
    rd(4);
    rst = 1'b1; wr(4, 32'h12345678, 4'b1111, 1'b0);
    rst = 1'b0;
    repeat (17) idle();
    for (int a = 0; a < 16; a++) rd(a);
    repeat (3) idle();

    // Parity injection then repair of byte 0 only
    wr(2, 32'h01020304, 4'b1111, 1'b1);
    rd(2);
    wr(2, 32'h00000004, 4'b0001, 1'b0);
    rd(2);
    repeat (3) idle();

    repeat (300) rnd_op();
    repeat (4) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sp_ram_pl.md
Name: sp_ram_pl

Overview:
- Next-generation single-port synchronous RAM for the rtl_lib.
- Adds per-byte write enables and a configurable registered read latency with an `rd_valid` strobe.
- Adds a post-reset hardware clear sequence with a `busy` flag, plus optional per-byte parity.
- Drop-in storage for register files and small buffers; behavioural array, no vendor macros.

Parameters:
- `add_wd`, 4: address width.
- `data_wd`, 32: data width; must be a multiple of 8.
- `depth`, 16: number of words; must be ≤ 2^`add_wd`.
- `rd_lat`, 2: read latency in cycles, legal range 1..4.
- `wr_thru`, 0: 1 = a write also returns the merged word on `rd_data` with `rd_valid`.

Ports:
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `cs`  in  1  access request.
- `rnw`  in  1  1 = read, 0 = write.
- `add`  in  `add_wd`  word address.
- `wr_data`  in  `data_wd`  write data.
- `wr_be`  in  `data_wd`/8  byte enables; bit i covers `wr_data[8i+7:8i]`.
- `par_inj`  in  1  invert stored parity on this write (test only).
- `rd_data`  out  `data_wd`  read data.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_data`.
- `rd_perr`  out  `data_wd`/8  per-byte parity error, aligned with `rd_valid`.
- `busy`  out  1  clear sequence running; accesses are ignored.

Behaviour:
- Reset (sampled `rst` = 1) forces:
  - `busy` = 1, state = CLEAR, clear counter = 0.
  - `rd_valid`, the valid pipeline and `rd_perr` = 0; `rd_data` = 0.
  - Memory contents are not touched during `rst`.
- FSM states:
  - CLEAR: write 0 (and even parity) to word[cnt], cnt++. When cnt = `depth`-1, go to READY. `busy` falls on the first READY cycle, so `busy` is high for exactly `depth` cycles after `rst` falls.
  - READY: accepts accesses. No other states.
- Reset mid-operation (in any state):
  - In-flight reads are discarded; no `rd_valid` is produced.
  - Clear restarts from address 0.
  - A write sampled in the same cycle as `rst` is dropped.
- `cs` while `busy`: ignored; no write, no `rd_valid`, no error indication.
- Read (`cs` & `rnw`, READY): `rd_data` and `rd_valid` appear exactly `rd_lat` cycles after the sampling edge.
  - Back-to-back reads are allowed every cycle; throughput is 1 per cycle.
- Write (`cs` & !`rnw`, READY):
  - Bytes with `wr_be[i]` = 1 are updated on the sampling edge; other bytes keep their value.
  - `wr_be` = 0 means no change.
- Read after write: a read of the same address in the next cycle returns the new data (no bypass hazard; the write commits at the edge).
- `wr_thru` = 1: a write also launches the merged new word down the read pipe, with `rd_valid` after `rd_lat` cycles. `wr_thru` = 0: writes produce no `rd_valid`.
- Out of range (`add` ≥ `depth`): write dropped; read returns 0 with `rd_valid` and `rd_perr` = 0.
- `rd_data` holds its last value between valid pulses; it never goes to X.
- Pipeline: the array read is registered in stage 1, followed by `rd_lat`-1 further register stages. Data and valid travel together.

Optional Feature:
- Macro: `SP_RAM_PARITY_EN`.
- Defined:
  - Each byte stores one even-parity bit, written only when its `wr_be` bit is set. `par_inj` inverts the written parity bits.
  - On read, parity is recomputed and `rd_perr[i]` = 1 on mismatch, aligned with `rd_valid`.
  - Clear writes correct parity.
- Undefined:
  - No parity storage; `rd_perr` is tied to 0 and `par_inj` is ignored.
  - Port list is unchanged.

Decomposition:
- Package `sp_ram_pkg` holds:
  - FSM state encoding (CLEAR, READY).
  - `RD_LAT_MAX` = 4.
  - Function `byte_par` (per-byte XOR vector).
- Sub-module `sp_ram_rd_pipe`: parametrised delay line (width, stages) carrying data, valid and perr. It is instantiated once with `rd_lat`-1 stages; with 0 stages it is a pass-through.

Test Plan (defaults `add_wd`=4, `data_wd`=32, `depth`=16, `rd_lat`=2):
- Clear timing: `rst` high 3 cycles, then low → `busy` = 1 for 16 cycles; afterwards reads of addresses 0..15 all return 0x00000000. `cs` pulses during `busy` produce no `rd_valid`.
- Byte-enable write: write 0xAABBCCDD to addr 3 with `wr_be`=1111, then 0x11223344 with `wr_be`=0101 → read addr 3 gives 0xAA22CC44 with `rd_valid` 2 cycles after the read edge.
- Streaming reads: 16 consecutive read cycles → 16 consecutive `rd_valid` pulses, with data in address order and no gaps.
- Mid-clear reset: assert `rst` at clear count 7 → `busy` restarts and stays high 16 cycles from `rst` release. A read issued one cycle before `rst` yields no `rd_valid`.
- `wr_thru`=1 build: write 0xDEADBEEF with `wr_be`=1111 at addr 5 → `rd_valid` 2 cycles later with `rd_data` = 0xDEADBEEF.
- Parity (`SP_RAM_PARITY_EN`): write 0x01020304 with `par_inj`=1, then read → `rd_perr`=1111. Rewrite byte 0 only without injection → `rd_perr`=1110.
